// File: rtl/hamming_enc_arbiter_pkg.sv
// Shared constants and types for the round-robin Hamming encoder arbiter.
// Optional SECDED overall-parity bit is enabled by HAMMING_ENC_ARBITER_SECDED_EN.
package hamming_enc_arbiter_pkg;

    localparam int DATA_W    = 8;
    localparam int CW_BASE_W = 12;

    // Hamming positions (1-based) that hold parity bits.
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;

`ifdef HAMMING_ENC_ARBITER_SECDED_EN
    localparam int CW_W = CW_BASE_W + 1;
`else
    localparam int CW_W = CW_BASE_W;
`endif

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/hamming_enc_arbiter_hamming.sv
// Combinational (12,8) Hamming encoder: codeword bit k holds Hamming position k+1,
// even parity at positions 1, 2, 4 and 8.
module hamming
    import hamming_enc_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]    data,
    output logic [CW_BASE_W-1:0] cw
);

    logic [CW_BASE_W:1] pos;

    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every bit a default first, so no latch is inferred.
        pos     = '0;
        pos[3]  = data[0];
        pos[5]  = data[1];
        pos[6]  = data[2];
        pos[7]  = data[3];
        pos[9]  = data[4];
        pos[10] = data[5];
        pos[11] = data[6];
        pos[12] = data[7];
        // Each parity bit is the XOR of all data positions whose index has that bit set.
        for (int k = 1; k <= CW_BASE_W; k++) begin
            if (k != P1_POS && (k & P1_POS) != 0) pos[P1_POS] = pos[P1_POS] ^ pos[k];
            if (k != P2_POS && (k & P2_POS) != 0) pos[P2_POS] = pos[P2_POS] ^ pos[k];
            if (k != P4_POS && (k & P4_POS) != 0) pos[P4_POS] = pos[P4_POS] ^ pos[k];
            if (k != P8_POS && (k & P8_POS) != 0) pos[P8_POS] = pos[P8_POS] ^ pos[k];
        end
        cw = pos;
    end

endmodule

// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter sharing one Hamming encoder among NUM_REQ byte producers,
// with a single registered output slot. HAMMING_ENC_ARBITER_SECDED_EN adds bit 12.
module hamming_enc_arbiter
    import hamming_enc_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SRC_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [CW_W-1:0]           out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
);

    state_t                state;
    logic [SRC_W-1:0]      rr_last;
    logic                  slot_free;
    logic                  grant_any;
    logic                  grant_en;
    logic [SRC_W-1:0]      grant_idx;
    logic [DATA_W-1:0]     enc_in;
    logic [CW_BASE_W-1:0]  enc_cw;
    logic [CW_W-1:0]       cw_next;

    // Returns {found, index} of the first valid requester after 'last', wrapping.
    function automatic logic [SRC_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [SRC_W-1:0]   last);
        logic [SRC_W:0] r;
        int             idx;
        r = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!r[SRC_W] && valid[idx]) r = {1'b1, SRC_W'(idx)};
        end
        return r;
    endfunction

    assign slot_free = (state == EMPTY) || out_ready;

    always_comb begin
        {grant_any, grant_idx} = rr_pick(req_valid, rr_last);
    end

    assign grant_en  = rst && slot_free && grant_any;
    assign req_ready = grant_en ? (NUM_REQ'(1) << grant_idx) : '0;
    assign enc_in    = req_data[int'(grant_idx)*DATA_W +: DATA_W];

    hamming u_hamming (
        .data (enc_in),
        .cw   (enc_cw)
    );

`ifdef HAMMING_ENC_ARBITER_SECDED_EN
    assign cw_next = {^enc_cw, enc_cw};
`else
    assign cw_next = enc_cw;
`endif

    assign out_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_src  <= '0;
            rr_last  <= SRC_W'(NUM_REQ - 1);
        end else if (grant_en) begin
            state    <= FULL;
            out_data <= cw_next;
            out_src  <= grant_idx;
            rr_last  <= grant_idx;
        end else if (state == FULL && out_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Directed self-checking bench for hamming_enc_arbiter; expected codewords hand-computed.
// Honours HAMMING_ENC_ARBITER_SECDED_EN for the expected bit 12.
module tb_hamming_enc_arbiter;
    import hamming_enc_arbiter_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int SRC_W   = 2;

`ifdef HAMMING_ENC_ARBITER_SECDED_EN
    localparam logic [31:0] CW_01 = 32'h1007;
    localparam logic [31:0] CW_FF = 32'h0F77;
    localparam logic [31:0] CW_80 = 32'h1888;
`else
    localparam logic [31:0] CW_01 = 32'h007;
    localparam logic [31:0] CW_FF = 32'hF77;
    localparam logic [31:0] CW_80 = 32'h888;
`endif

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [CW_W-1:0]           out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;

    int tests_run;
    int tests_failed;

    hamming_enc_arbiter #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] cw, input logic [31:0] src);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  cw);
        check({tag, "_src"},   32'(out_src),   src);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset held for two edges while requester 0 already offers 0x01.
        rst       = 1'b0;
        req_valid = 2'b01;
        req_data  = 16'h0001;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_src",   32'(out_src),   32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);

        rst = 1'b1;
        #1 check("first_ready", 32'(req_ready), 32'b01);
        @(negedge clk);
        check_out("enc_01", CW_01, 32'd0);

        // Requester 1 alone, all-ones byte.
        req_valid = 2'b10;
        req_data  = 16'hFF00;
        #1 check("ff_ready", 32'(req_ready), 32'b10);
        @(negedge clk);
        check_out("enc_ff", CW_FF, 32'd1);

        // Requester 0 with only the top data bit set.
        req_valid = 2'b01;
        req_data  = 16'h0080;
        #1 check("h80_ready", 32'(req_ready), 32'b01);
        @(negedge clk);
        check_out("enc_80", CW_80, 32'd0);

        // Backpressure: both requesting, slot full, out_ready low for 5 cycles.
        out_ready = 1'b0;
        req_valid = 2'b11;
        req_data  = 16'hFF01;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_ready", 32'(req_ready), 32'b00);
            @(negedge clk);
            check_out("bp_hold", CW_80, 32'd0);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(req_ready), 32'b10);
        @(negedge clk);
        check_out("bp_refill", CW_FF, 32'd1);
        #1 check("rr_next_ready", 32'(req_ready), 32'b01);
        @(negedge clk);
        check_out("rr_next", CW_01, 32'd0);

        // Reset while full; last grant was 0, so without reset 1 would be next.
        out_ready = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        rst       = 1'b1;
        out_ready = 1'b1;

        // Fairness: grants alternate 0,1,0,1,... with no idle cycles.
        for (int i = 0; i < 6; i++) begin
            #1 check("fair_ready", 32'(req_ready), (i % 2 == 0) ? 32'b01 : 32'b10);
            @(negedge clk);
            check_out("fair_out", (i % 2 == 0) ? CW_01 : CW_FF, 32'(i % 2));
        end

        // Idle drain, then out_ready pulses while empty change nothing.
        req_valid = 2'b00;
        #1 check("idle_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data",  32'(out_data),  CW_FF);
        check("drain_src",   32'(out_src),   32'd1);
        for (int i = 0; i < 4; i++) begin
            out_ready = i[0];
            @(negedge clk);
            check("empty_valid", 32'(out_valid), 32'd0);
            check("empty_data",  32'(out_data),  CW_FF);
            check("empty_ready", 32'(req_ready), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hamming_enc_arbiter.md
Name: hamming_enc_arbiter

Overview:
- Shares one `hamming` encoder instance (8-bit data in, 12-bit codeword out) between NUM_REQ requesters.
- Arbitration is round-robin.
- Each requester uses a valid/ready handshake; the block presents a registered codeword plus source ID downstream with its own valid/ready.
- Sits between byte producers and the channel/serializer stage.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- SRC_W, 2, width of out_src; must satisfy 2**SRC_W >= NUM_REQ.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk; 0 = reset.
- req_valid  in  NUM_REQ  bit i: requester i offers a byte.
- req_data  in  8*NUM_REQ  requester i byte at [8*i+7:8*i].
- req_ready  out  NUM_REQ  one-hot or zero; bit i: requester i's byte accepted this cycle.
- out_valid  out  1  codeword slot holds valid data.
- out_data  out  CW_W  codeword; CW_W=12, or 13 with the optional feature.
- out_src  out  SRC_W  index of the requester that produced out_data.
- out_ready  in  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (rst=0 at a clock edge): out_valid=0, out_data=0, out_src=0, state=EMPTY, rr_last=NUM_REQ-1 so requester 0 has top priority. req_ready is combinational and is 0 whenever rst=0.
- Codeword layout: out_data[k] = Hamming position k+1.
  - Parity bits at positions 1,2,4,8; data d0..d7 at positions 3,5,6,7,9,10,11,12.
  - Even parity: p1 covers 1,3,5,7,9,11; p2 covers 2,3,6,7,10,11; p4 covers 4,5,6,7,12; p8 covers 8..12.
- FSM has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Slot is free when state=EMPTY, or when state=FULL and out_ready=1 (drain and refill in the same cycle, no bubble).
- Grant (combinational):
  - If the slot is free, grant the first requester with req_valid=1, scanning rr_last+1, rr_last+2, … modulo NUM_REQ.
  - Drive req_ready high for that requester only.
  - No grant if the slot is not free. req_ready never depends on req_valid of other requesters beyond this priority scan.
- Accept (grant at edge T):
  - out_data <= encode(req_data[g]); out_src <= g; rr_last <= g; state <= FULL.
  - out_valid is high from T+1. Latency is 1 cycle, and throughput is 1 codeword per cycle under continuous out_ready=1.
- Drain without new grant (FULL, out_ready=1, no req_valid): state <= EMPTY. out_data and out_src hold their last value.
- Backpressure (FULL, out_ready=0): out_data and out_src stay stable, all req_ready=0, rr_last unchanged.
- rr_last updates only on a grant. With a single active requester, it is granted every free cycle.
- The encoder is combinational; its inputs are muxed by the grant, and its output is registered only on accept.
- Reset mid-transfer discards the held codeword; no partial state survives.
- out_ready while EMPTY is ignored.

Optional Feature:
- Macro: HAMMING_ENC_ARBITER_SECDED_EN.
- Defined: CW_W=13; out_data[12] = XOR of out_data[11:0] (overall parity, SECDED).
- Undefined: CW_W=12; no bit 12 exists.
- Arbitration, handshake and latency are identical in both builds.

Decomposition:
- Shared package holds:
  - DATA_W=8, CW_BASE_W=12.
  - Parity position constants (1,2,4,8).
  - The CW_W derivation under the macro.
  - The FSM state typedef {EMPTY, FULL}.
- Sub-module: reuse the existing `hamming` encoder as the single instantiated child.
- Round-robin pick stays inline as a function; no separate module.

Test Plan:
- Reset then single request: rst low 2 cycles; req_valid=01, req_data[7:0]=0x01, out_ready=1.
  - req_ready[0]=1 at first cycle after reset; next cycle out_valid=1, out_data=0x007, out_src=0.
  - SECDED build: out_data=0x1007.
- Encoding of 0xFF from requester 1: req_valid=10, data 0xFF.
  - out_data=0xF77, out_src=1; SECDED build: 0x0F77.
- Fairness: both req_valid held high with data 0x01/0xFF, out_ready=1.
  - Grants alternate 0,1,0,1 starting with 0 after reset.
  - out_src alternates each cycle, with no idle cycles.
- Backpressure: hold out_ready=0 for 5 cycles with the slot FULL.
  - out_data and out_src constant, req_ready=00.
  - On out_ready=1, drain and new grant occur in the same cycle.
- Reset mid-operation: slot FULL, out_ready=0, assert rst for 1 cycle.
  - Next cycle out_valid=0, out_data=0, and requester 0 has priority regardless of the prior rr_last.
- Idle drain: slot FULL, out_ready=1, no req_valid.
  - out_valid falls next cycle; out_ready pulses while EMPTY cause no change.
